btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Conditions the raw push-buttons and floor switches before they reach the input processor, so it only sees clean signals.
- For each channel it synchronizes to the scan clock domain, debounces, and emits a debounced level, one-cycle press/release pulses and a long-press flag.
- Sits directly upstream of the input processor and the status transition door-button inputs, clocked by the divided input-scan clock.

Parameters:
- NUM_IN, 13, number of independent channels (5 buttons + 8 floor switches).
- DEBOUNCE_CYCLES, 20, consecutive stable synchronized samples required to accept a change (≥1).
- HOLD_CYCLES, 10000, cycles of debounced-high before the long-press flag is asserted (≥1).

Ports:
- clk  in  1  input-scan clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- raw_in  in  NUM_IN  raw asynchronous button/switch levels.
- level  out  NUM_IN  debounced level per channel.
- press  out  NUM_IN  one-cycle pulse when level rises.
- release  out  NUM_IN  one-cycle pulse when level falls.
- hold  out  NUM_IN  high while level has been high ≥ HOLD_CYCLES cycles.

Behaviour:
- Reset (rst=0, async): sync flops, level, press, release, hold and all counters are forced to 0 immediately. Reset release is synchronous to the next edge; no pulse is generated on reset exit.
- Synchronizer: 2-flop chain per channel, q1 then q2. Only q2 feeds the debounce logic.
- Debounce counter width is clog2(DEBOUNCE_CYCLES)+1 per channel. Each edge:
  - q2==level: counter cleared to 0. Any glitch shorter than DEBOUNCE_CYCLES samples restarts the count.
  - q2!=level and counter==DEBOUNCE_CYCLES-1: level<=q2, counter<=0.
  - otherwise: counter++.
- Latency: raw_in stable from before edge 1 gives q2 valid at edge 2. level changes at edge DEBOUNCE_CYCLES+2. With the default, that is 22 cycles (~2.2 ms at the 10 kHz scan clock).
- press/release are registered: high for exactly the one cycle after the edge where level flips (same edge level updates), low otherwise. press and release are never both high on one channel.
- Hold counter width is clog2(HOLD_CYCLES)+1 per channel.
  - Cleared while level==0.
  - Increments each cycle level==1, saturating at HOLD_CYCLES.
  - hold=1 when counter==HOLD_CYCLES. It asserts HOLD_CYCLES edges after the level rise and deasserts on the same edge level falls.
- Channels are fully independent; simultaneous changes on several channels are processed in parallel with no priority.
- Input held high through reset release: treated as a new press. level rises DEBOUNCE_CYCLES+2 edges after rst goes high, with a press pulse.
- Reset asserted mid-debounce or mid-hold: pending count is discarded. After release, counting restarts from 0.
- Bouncing input alternating faster than DEBOUNCE_CYCLES: level never changes, no pulses.
- DEBOUNCE_CYCLES=1: level follows q2 with one extra cycle of delay (edge 3).

Decomposition:
- Shared package (elevator_pkg):
  - default DEBOUNCE_CYCLES/HOLD_CYCLES constants, derived from the scan-clock divider constant;
  - channel index constants BTN_UP, BTN_DOWN, BTN_OPEN, BTN_CLOSE, BTN_OUTSIDE, SW_BASE.
- One sub-module, btn_channel: synchronizer, debounce counter, hold counter and pulse regs for a single bit. It is instantiated NUM_IN times via generate; the top-level block is wiring only.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, NUM_IN=13):
- Reset: rst=0 with raw_in=all ones, mid-run → all outputs 0 immediately. Release rst → level=13'h1FFF and a single press pulse of all ones at edge 6; no release.
- Clean press: raw_in[0] 0→1 set up before edge 1 → level[0]=1 and press[0]=1 at edge 6. press[0]=0 at edge 7. Other channels unchanged.
- Glitch rejection: raw_in[1] high for 3 cycles then low → level[1], press[1], release[1] stay 0 throughout. Repeat with a 4-cycle high → press asserts.
- Release and hold: hold raw_in[2] high → hold[2]=1 exactly 16 edges after level[2] rose. Drop raw_in[2] → release[2]=1 and hold[2]=0 on the same edge, 6 edges after the drop.
- Simultaneous channels: raw_in[3] rises and raw_in[4] falls (previously stable high) in the same cycle → press[3] and release[4] pulse on the same edge. No cross-channel effect.
- Reset mid-debounce: raw_in[5] rises, rst pulsed low at edge 3 → no press. After release, press[5] occurs 6 edges after rst rise.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared constants for the elevator controller slice: scan-clock timing and
// the channel map used by the button conditioner and its consumers.
package elevator_pkg;

  // The input-scan clock is the system clock divided down; timing defaults
  // below are derived from it so a divider change keeps the same milliseconds.
  localparam int SYS_CLK_HZ   = 50_000_000;
  localparam int SCAN_CLK_DIV = 5_000;
  localparam int SCAN_CLK_HZ  = SYS_CLK_HZ / SCAN_CLK_DIV;

  localparam int DEBOUNCE_MS = 2;
  localparam int HOLD_MS     = 1000;

  localparam int DEBOUNCE_CYCLES_DEF = SCAN_CLK_HZ * DEBOUNCE_MS / 1000;
  localparam int HOLD_CYCLES_DEF     = SCAN_CLK_HZ * HOLD_MS / 1000;

  localparam int NUM_BTN    = 5;
  localparam int NUM_SW     = 8;
  localparam int NUM_IN_DEF = NUM_BTN + NUM_SW;

  // Channel map: buttons first, floor switches from SW_BASE upward.
  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_OPEN    = 2;
  localparam int BTN_CLOSE   = 3;
  localparam int BTN_OUTSIDE = 4;
  localparam int SW_BASE     = 5;

  // Counter width that can hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// Single-bit conditioner: 2-flop synchronizer, debounce, edge pulses and
// long-press detection.
module btn_channel
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int HD_W = cnt_width(HOLD_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_MAX  = HD_W'(HOLD_CYCLES);

  logic            r_q1;
  logic            r_q2;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic [DB_W-1:0] r_db_cnt;
  logic [HD_W-1:0] r_hd_cnt;
  logic            w_differs;
  logic            w_accept;

  assign w_differs = (r_q2 != r_level);
  assign w_accept  = w_differs && (r_db_cnt == DB_LAST);

  // Bring the asynchronous raw level into the scan-clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= i_raw;
      r_q2 <= r_q1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (!w_differs) begin
      r_db_cnt <= '0;
    end else if (w_accept) begin
      r_db_cnt <= '0;
      r_level  <= r_q2;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // One-cycle pulses registered on the same edge the level flips.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_accept && r_q2;
      r_release <= w_accept && !r_q2;
    end
  end

  // Count high time, saturating; cleared on the falling edge itself so the
  // hold flag drops together with the level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hd_cnt <= '0;
    end else if (!r_level || w_accept) begin
      r_hd_cnt <= '0;
    end else if (r_hd_cnt != HD_MAX) begin
      r_hd_cnt <= r_hd_cnt + 1'b1;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_hold    = (r_hd_cnt == HD_MAX);

endmodule

// File: rtl/btn_conditioner.sv
// Conditions every raw button/switch channel independently; wiring only.
module btn_conditioner
  import elevator_pkg::*;
#(
  parameter int NUM_IN          = NUM_IN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_IN-1:0] i_raw_in,
  output logic [NUM_IN-1:0] o_level,
  output logic [NUM_IN-1:0] o_press,
  output logic [NUM_IN-1:0] o_release,
  output logic [NUM_IN-1:0] o_hold
);

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_raw    (i_raw_in[g]),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_hold   (o_hold[g])
    );
  end

endmodule
